// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier: low WIDTH bits of multiplicand*multiplier, fixed WIDTH-cycle RUN then a one-cycle DONE.
// stall holds the pipeline from the accepting cycle through RUN; start is ignored while busy.
module mul_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             wr_en,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]    count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          mcand_d   = multiplicand;
          mplier_d  = multiplier;
          product_d = '0;
          count_d   = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) product_d = product_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Saturate on the final cycle so the counter never wraps back to zero.
        if (count_q == LAST) begin
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign wr_en   = done;
  assign product = product_q;
  // Gated by reset so a start seen during reset cannot freeze the PC.
  assign stall   = reset && (((state_q == IDLE) && start) || (state_q == RUN));

endmodule
